// File: rtl/bus_word_assembler_if.sv
// Bus-side capture interface: load strobes and bus value in, assembled operand and status out.
interface bus_word_assembler_if #(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [BUS_WIDTH-1:0]  i_bus_data;
    logic                  i_load_byte;
    logic                  i_load_word;
    logic                  i_consume;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_half;
    logic                  o_overrun;
    logic                  o_conflict;

    modport slave (
        input  i_bus_data, i_load_byte, i_load_word, i_consume,
        output o_data, o_valid, o_half, o_overrun, o_conflict
    );

    modport master (
        output i_bus_data, i_load_byte, i_load_word, i_consume,
        input  o_data, o_valid, o_half, o_overrun, o_conflict
    );
endinterface

// File: rtl/bus_word_assembler.sv
// Assembles a 16-bit operand from one word load or two byte loads (low then high)
// and flags overrun and simultaneous-strobe misuse with sticky bits.
module bus_word_assembler #(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input logic                  i_clk,
    input logic                  i_reset,
    bus_word_assembler_if.slave  io_bus
);
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHalf  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_overrun;
    logic                  r_conflict;

    state_e                w_state_eff;
    state_e                w_state_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_overrun_next;
    logic                  w_conflict_next;
    logic [BYTE_WIDTH-1:0] w_byte;

    assign w_byte = io_bus.i_bus_data[BYTE_WIDTH-1:0];

    always_comb begin
        // Consume acts before the load; the unused encoding also falls back to empty.
        w_state_eff = r_state;
        if (io_bus.i_consume || (r_state != StHalf && r_state != StFull)) begin
            w_state_eff = StEmpty;
        end

        w_state_next    = w_state_eff;
        w_data_next     = r_data;
        w_overrun_next  = r_overrun;
        w_conflict_next = r_conflict;

        if (io_bus.i_load_word) begin
            w_data_next  = io_bus.i_bus_data[DATA_WIDTH-1:0];
            w_state_next = StFull;
            if (io_bus.i_load_byte) begin
                w_conflict_next = 1'b1;
            end
        end else if (io_bus.i_load_byte) begin
            case (w_state_eff)
                StHalf: begin
                    w_data_next[DATA_WIDTH-1:BYTE_WIDTH] = w_byte;
                    w_state_next                         = StFull;
                end
                StFull: begin
                    w_overrun_next = 1'b1;
                end
                default: begin
                    w_data_next  = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, w_byte};
                    w_state_next = StHalf;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StEmpty;
            r_data     <= '0;
            r_overrun  <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_data     <= w_data_next;
            r_overrun  <= w_overrun_next;
            r_conflict <= w_conflict_next;
        end
    end

    assign io_bus.o_data     = r_data;
    assign io_bus.o_valid    = (r_state == StFull);
    assign io_bus.o_half     = (r_state == StHalf);
    assign io_bus.o_overrun  = r_overrun;
    assign io_bus.o_conflict = r_conflict;
endmodule

// File: tb/tb_bus_word_assembler.sv
// Directed scenarios plus randomized traffic checked against a byte-count model.
module tb_bus_word_assembler;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    // Reference model: number of bytes held (0, 1, 2) and the operand register.
    int          m_bytes;
    logic [15:0] m_data;
    logic        m_ovr;
    logic        m_cnf;

    bus_word_assembler_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) bif ();

    bus_word_assembler #(
        .BUS_WIDTH (16),
        .BYTE_WIDTH(8),
        .DATA_WIDTH(16)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .io_bus (bif)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic lb, input logic lw, input logic cons,
                        input logic [15:0] bus);
        rst             = r;
        bif.i_load_byte = lb;
        bif.i_load_word = lw;
        bif.i_consume   = cons;
        bif.i_bus_data  = bus;
        if (r) begin
            m_bytes = 0;
            m_data  = 16'h0000;
            m_ovr   = 1'b0;
            m_cnf   = 1'b0;
        end else begin
            if (cons) m_bytes = 0;
            if (lw) begin
                m_data  = bus;
                m_bytes = 2;
                if (lb) m_cnf = 1'b1;
            end else if (lb) begin
                if (m_bytes == 0) begin
                    m_data  = bus % 256;
                    m_bytes = 1;
                end else if (m_bytes == 1) begin
                    m_data  = (bus % 256) * 256 + (m_data % 256);
                    m_bytes = 2;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bif.i_load_byte = 1'b0;
        bif.i_load_word = 1'b0;
        bif.i_consume   = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        n_cmp++;
        if ({bif.o_valid, bif.o_half, bif.o_overrun, bif.o_conflict, bif.o_data} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v%b h%b o%b c%b d=%h want all zero", bif.o_valid,
                     bif.o_half, bif.o_overrun, bif.o_conflict, bif.o_data);
        end
    endtask

    task automatic test_byte_pair();
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0034);
        n_cmp++;
        if (bif.o_half !== 1'b1 || bif.o_valid !== 1'b0 || bif.o_data !== 16'h0034) begin
            n_fail++;
            $display("FAIL byte_low: got h%b v%b d=%h want h1 v0 d=0034", bif.o_half,
                     bif.o_valid, bif.o_data);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0012);
        n_cmp++;
        if (bif.o_valid !== 1'b1 || bif.o_half !== 1'b0 || bif.o_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL byte_high: got v%b h%b d=%h want v1 h0 d=1234", bif.o_valid,
                     bif.o_half, bif.o_data);
        end
    endtask

    task automatic test_word_consume();
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
        n_cmp++;
        if (bif.o_valid !== 1'b1 || bif.o_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL word_load: got v%b d=%h want v1 d=beef", bif.o_valid, bif.o_data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        n_cmp++;
        if (bif.o_valid !== 1'b0 || bif.o_half !== 1'b0 || bif.o_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL word_consume: got v%b h%b d=%h want v0 h0 d=beef", bif.o_valid,
                     bif.o_half, bif.o_data);
        end
    endtask

    task automatic test_overrun();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFF34);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hEE12);
        n_cmp++;
        if (bif.o_data !== 16'h1234 || bif.o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_setup: got d=%h o%b want d=1234 o0", bif.o_data,
                     bif.o_overrun);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h00AA);
        n_cmp++;
        if (bif.o_data !== 16'h1234 || bif.o_valid !== 1'b1 || bif.o_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got d=%h v%b o%b want d=1234 v1 o1", bif.o_data,
                     bif.o_valid, bif.o_overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h5555);
        n_cmp++;
        if (bif.o_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b want 1", bif.o_overrun);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        n_cmp++;
        if (bif.o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b want 0", bif.o_overrun);
        end
    endtask

    task automatic test_consume_load();
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0056);
        n_cmp++;
        if (bif.o_half !== 1'b1 || bif.o_valid !== 1'b0 || bif.o_data !== 16'h0056 ||
            bif.o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL consume_byte: got h%b v%b o%b d=%h want h1 v0 o0 d=0056",
                     bif.o_half, bif.o_valid, bif.o_overrun, bif.o_data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        n_cmp++;
        if (bif.o_half !== 1'b0 || bif.o_valid !== 1'b0 || bif.o_data !== 16'h0056) begin
            n_fail++;
            $display("FAIL half_abort: got h%b v%b d=%h want h0 v0 d=0056", bif.o_half,
                     bif.o_valid, bif.o_data);
        end
    endtask

    task automatic test_conflict();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'hCAFE);
        n_cmp++;
        if (bif.o_valid !== 1'b1 || bif.o_data !== 16'hCAFE || bif.o_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict: got v%b c%b d=%h want v1 c1 d=cafe", bif.o_valid,
                     bif.o_conflict, bif.o_data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        n_cmp++;
        if (bif.o_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_sticky: got %b want 1", bif.o_conflict);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0034);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0012);
        n_cmp++;
        if ({bif.o_valid, bif.o_half, bif.o_overrun, bif.o_conflict, bif.o_data} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got v%b h%b o%b c%b d=%h want all zero", bif.o_valid,
                     bif.o_half, bif.o_overrun, bif.o_conflict, bif.o_data);
        end
    endtask

    task automatic test_random();
        logic [19:0] got;
        logic [19:0] want;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 47) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 16'($urandom));
            got  = {bif.o_valid, bif.o_half, bif.o_overrun, bif.o_conflict, bif.o_data};
            want = {(m_bytes == 2), (m_bytes == 1), m_ovr, m_cnf, m_data};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                if (n_fail < 20) begin
                    $display("FAIL random[%0d]: got v/h/o/c/d=%h want %h", i, got, want);
                end
            end
        end
    endtask

    initial begin
        clk             = 1'b0;
        rst             = 1'b0;
        n_cmp           = 0;
        n_fail          = 0;
        m_bytes         = 0;
        m_data          = 16'h0000;
        m_ovr           = 1'b0;
        m_cnf           = 1'b0;
        bif.i_bus_data  = 16'h0000;
        bif.i_load_byte = 1'b0;
        bif.i_load_word = 1'b0;
        bif.i_consume   = 1'b0;
        #2;
        test_reset();
        test_byte_pair();
        test_word_consume();
        test_overrun();
        test_consume_load();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
